regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port between two writers: the in-order writeback stage, and an out-of-band long-latency unit (multi-cycle mul/div, late load returns).
- The writeback stage has priority. Long-latency results queue in a small FIFO and drain into idle port cycles.
- A starvation counter stalls writeback so that queued results always drain.
- Sits between the writeback stage / long-latency unit and the register file write port. Also exports a pending-write query for the issue scoreboard.

---
 rtl/regfile_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the in-order
//   writeback stage (priority) and an out-of-band long-latency unit whose
//   results queue in a small FIFO and drain into idle port cycles. A
//   starvation counter forcibly stalls writeback so queued results always
//   drain. Also answers a pending-write query for the issue scoreboard.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wb_en/wb_addr/wb_val      writeback stage write request
//   wb_stall                  writeback must re-present its write
//   lu_valid/lu_addr/lu_val   long-latency result offer
//   lu_ready                  FIFO can accept a result
//   rf_en/rf_addr/rf_val      register file write port
//   q_addr/q_hit              scoreboard query: queued write to q_addr
//   pend_busy                 FIFO non-empty
module regfile_write_arbiter #(
  parameter int XLEN       = 32,
  parameter int REG_W      = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_addr,
  input  logic [XLEN-1:0]  wb_val,
  output logic             wb_stall,
  input  logic             lu_valid,
  input  logic [REG_W-1:0] lu_addr,
  input  logic [XLEN-1:0]  lu_val,
  output logic             lu_ready,
  output logic             rf_en,
  output logic [REG_W-1:0] rf_addr,
  output logic [XLEN-1:0]  rf_val,
  input  logic [REG_W-1:0] q_addr,
  output logic             q_hit,
  output logic             pend_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_WB,
    GRANT_HEAD,
    GRANT_FORCE
  } grant_e;

  logic [REG_W-1:0] addr_q [DEPTH];
  logic [XLEN-1:0]  val_q  [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             empty;
  logic             full;
  logic             force_drain;
  logic             push;
  logic             pop;
  logic [PW-1:0]    occupancy;
  logic [AW-1:0]    head_idx;
  grant_e           grant;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign occupancy   = wr_ptr_q - rd_ptr_q;
  assign head_idx    = rd_ptr_q[AW-1:0];
  assign force_drain = !empty && (cnt_q == CW'(STARVE_MAX));

  // Both handshake outputs come from registered state only, gated by reset.
  assign lu_ready  = !full && !rst;
  assign wb_stall  = force_drain && !rst;
  assign pend_busy = !empty;

  // x0 results are acknowledged but dropped.
  assign push = lu_valid && lu_ready && (lu_addr != '0);
  assign pop  = (grant == GRANT_HEAD) || (grant == GRANT_FORCE);

  always_comb begin
    grant = GRANT_NONE;
    if (rst)              grant = GRANT_NONE;
    else if (force_drain) grant = GRANT_FORCE;
    else if (wb_en)       grant = GRANT_WB;
    else if (!empty)      grant = GRANT_HEAD;
  end

  always_comb begin
    rf_en   = 1'b0;
    rf_addr = '0;
    rf_val  = '0;
    unique case (grant)
      GRANT_WB: begin
        rf_en   = 1'b1;
        rf_addr = wb_addr;
        rf_val  = wb_val;
      end
      GRANT_HEAD, GRANT_FORCE: begin
        rf_en   = 1'b1;
        rf_addr = addr_q[head_idx];
        rf_val  = val_q[head_idx];
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (grant == GRANT_WB && !empty) begin
      // Head denied in favour of writeback; saturate at the limit.
      cnt_d = (cnt_q == CW'(STARVE_MAX)) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? PW'(1) : PW'(0));
    rd_ptr_d = rd_ptr_q + (pop  ? PW'(1) : PW'(0));
  end

  // A slot is live when its distance from the head is below occupancy;
  // the head being popped this cycle still counts.
  always_comb begin
    logic [AW-1:0] off;
    q_hit = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head_idx;
      if ((PW'(off) < occupancy) && (addr_q[i] == q_addr) && (q_addr != '0))
        q_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q[AW-1:0]] <= lu_addr;
      val_q[wr_ptr_q[AW-1:0]]  <= lu_val;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_en;
  logic [REG_W-1:0] wb_addr;
  logic [XLEN-1:0]  wb_val;
  logic             wb_stall;
  logic             lu_valid;
  logic [REG_W-1:0] lu_addr;
  logic [XLEN-1:0]  lu_val;
  logic             lu_ready;
  logic             rf_en;
  logic [REG_W-1:0] rf_addr;
  logic [XLEN-1:0]  rf_val;
  logic [REG_W-1:0] q_addr;
  logic             q_hit;
  logic             pend_busy;

  int tests = 0;
  int fails = 0;

  regfile_write_arbiter #(
    .XLEN(XLEN), .REG_W(REG_W), .DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_val(wb_val), .wb_stall(wb_stall),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_val(lu_val), .lu_ready(lu_ready),
    .rf_en(rf_en), .rf_addr(rf_addr), .rf_val(rf_val),
    .q_addr(q_addr), .q_hit(q_hit), .pend_busy(pend_busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [REG_W-1:0] addr;
    logic [XLEN-1:0]  val;
  } ent_t;

  // Reference model: queue of pending results plus a denial count.
  ent_t mq[$];
  int   mcnt = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [REG_W-1:0] a);
    bit h = 0;
    if (a != 0)
      foreach (mq[i]) if (mq[i].addr == a) h = 1;
    return h;
  endfunction

  // Compare process: inputs settle at posedge+1, outputs checked at negedge,
  // then the model advances to the state after the following posedge.
  always @(negedge clk) begin
    logic e_ready, e_stall, e_en, do_pop;
    ent_t e_w;
    e_ready = 0; e_stall = 0; e_en = 0; do_pop = 0; e_w = '0;
    if (!rst && wb_en && model_hit(wb_addr)) begin
      fails++;
      $display("FAIL stim_order wb_addr=%0d matches queued entry", wb_addr);
    end
    if (!rst) begin
      e_ready = (mq.size() < DEPTH);
      if (mq.size() > 0 && mcnt == SMAX) begin
        e_stall = 1; e_en = 1; e_w = mq[0]; do_pop = 1;
      end else if (wb_en) begin
        e_en = 1; e_w = {wb_addr, wb_val};
      end else if (mq.size() > 0) begin
        e_en = 1; e_w = mq[0]; do_pop = 1;
      end
    end
    chk("lu_ready", lu_ready, e_ready);
    chk("wb_stall", wb_stall, e_stall);
    chk("rf_en", rf_en, e_en);
    chk("pend_busy", pend_busy, mq.size() > 0);
    chk("q_hit", q_hit, model_hit(q_addr));
    if (e_en) begin
      chk("rf_addr", rf_addr, e_w.addr);
      chk("rf_val", rf_val, e_w.val);
    end
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (!do_pop && wb_en && mq.size() > 0) mcnt = (mcnt < SMAX) ? mcnt + 1 : SMAX;
      else mcnt = 0;
      if (do_pop) void'(mq.pop_front());
      if (lu_valid && e_ready && lu_addr != 0) mq.push_back({lu_addr, lu_val});
    end
  end

  task automatic mid(); @(negedge clk); #1; endtask
  task automatic nxt(); @(posedge clk); #1; endtask

  initial begin
    rst = 1; wb_en = 0; wb_addr = 0; wb_val = 0;
    lu_valid = 0; lu_addr = 0; lu_val = 0; q_addr = 0;
    nxt(); nxt();
    mid();
    chk("rst_lu_ready", lu_ready, 0);
    chk("rst_wb_stall", wb_stall, 0);
    chk("rst_rf_en", rf_en, 0);
    nxt(); rst = 0;
    mid();
    chk("post_rst_rf_en", rf_en, 0);
    chk("post_rst_q_hit", q_hit, 0);
    chk("post_rst_pend", pend_busy, 0);
    chk("post_rst_lu_ready", lu_ready, 1);
    nxt();

    // Idle drain
    lu_valid = 1; lu_addr = 3; lu_val = 32'hAAAA0001;
    mid(); chk("drain_ready", lu_ready, 1); chk("drain_no_pass", rf_en, 0);
    nxt(); lu_valid = 0;
    mid();
    chk("drain_en", rf_en, 1); chk("drain_addr", rf_addr, 3);
    chk("drain_val", rf_val, 32'hAAAA0001); chk("drain_pend", pend_busy, 1);
    nxt();
    mid(); chk("drain_pend_low", pend_busy, 0); chk("drain_idle", rf_en, 0);
    nxt();

    // Writeback priority and forced drain
    wb_en = 1; wb_addr = 5; wb_val = 32'h55;
    lu_valid = 1; lu_addr = 7; lu_val = 32'h77;
    mid(); chk("prio_push_cyc", rf_addr, 5);
    nxt(); lu_valid = 0;
    for (int i = 0; i < SMAX; i++) begin
      mid(); chk("prio_wb_addr", rf_addr, 5); chk("prio_no_stall", wb_stall, 0);
      nxt();
    end
    mid(); chk("prio_force_stall", wb_stall, 1); chk("prio_force_addr", rf_addr, 7);
    nxt();
    mid(); chk("prio_after_stall", wb_stall, 0); chk("prio_after_addr", rf_addr, 5);
    chk("prio_after_pend", pend_busy, 0);
    nxt(); wb_en = 0;

    // x0 drop
    lu_valid = 1; lu_addr = 0; lu_val = 32'hDEAD; q_addr = 0;
    mid(); chk("x0_ready", lu_ready, 1); chk("x0_q_hit", q_hit, 0); chk("x0_rf_en", rf_en, 0);
    nxt(); lu_valid = 0;
    mid(); chk("x0_no_write", rf_en, 0); chk("x0_pend", pend_busy, 0);
    nxt();

    // Query, full FIFO, held third result, ordering
    wb_en = 1; wb_addr = 1; wb_val = 32'h11;
    lu_valid = 1; lu_addr = 9; lu_val = 32'h99;
    nxt(); lu_addr = 12; lu_val = 32'hC12;
    mid(); chk("full_ready_p2", lu_ready, 1);
    nxt(); lu_addr = 20; lu_val = 32'h20; q_addr = 9;
    mid();
    chk("full_ready_p3", lu_ready, 0);
    chk("q_hit_9", q_hit, 1);
    q_addr = 12; #1 chk("q_hit_12", q_hit, 1);
    q_addr = 10; #1 chk("q_hit_10", q_hit, 0);
    nxt();
    for (int i = 0; i < 2; i++) begin
      mid(); chk("full_held", lu_ready, 0); chk("full_wb", rf_addr, 1);
      nxt();
    end
    mid(); chk("full_force", wb_stall, 1); chk("full_force_addr", rf_addr, 9);
    chk("full_still_full", lu_ready, 0);
    nxt();
    mid(); chk("full_freed", lu_ready, 1); chk("full_wb_back", rf_addr, 1);
    nxt(); lu_valid = 0; wb_en = 0;
    mid(); chk("order_12", rf_addr, 12);
    nxt();
    mid(); chk("order_20", rf_addr, 20); chk("order_20_val", rf_val, 32'h20);
    nxt();
    mid(); chk("order_done", rf_en, 0);
    nxt();

    // Reset mid-operation
    wb_en = 1; wb_addr = 1; lu_valid = 1; lu_addr = 3; lu_val = 32'h3;
    nxt(); lu_addr = 4; lu_val = 32'h4;
    nxt(); lu_valid = 0;
    nxt(); nxt();
    rst = 1;
    mid(); chk("mrst_rf_en", rf_en, 0); chk("mrst_stall", wb_stall, 0); chk("mrst_ready", lu_ready, 0);
    nxt(); rst = 0; wb_en = 0;
    mid(); chk("mrst_after_en", rf_en, 0); chk("mrst_after_pend", pend_busy, 0);
    chk("mrst_after_ready", lu_ready, 1); chk("mrst_after_stall", wb_stall, 0);
    nxt();
    mid(); chk("mrst_discarded", rf_en, 0);
    nxt();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      wb_en    = ($urandom_range(0, 99) < 55);
      wb_val   = $urandom;
      do wb_addr = REG_W'($urandom); while (model_hit(wb_addr));
      lu_valid = ($urandom_range(0, 99) < 60);
      lu_addr  = ($urandom_range(0, 7) == 0) ? '0 : REG_W'($urandom);
      lu_val   = $urandom;
      q_addr   = REG_W'($urandom);
      nxt();
    end
    rst = 0; wb_en = 0; lu_valid = 0;
    repeat (4) nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
